// File: rtl/push_gear_ctrl.sv
// Push-switch gear selector: press events step PARK->LOW->MID->HIGH->PARK,
// the selected gear sets a target duty that is ramped one LSB per divider period into a PWM.
module push_gear_ctrl #(
  parameter int CNT_LEN  = 8,
  parameter int PWM_W    = 8,
  parameter int RAMP_DIV = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [CNT_LEN-1:0] i_push_cnt,
  input  logic               i_estop,
  output logic [1:0]         o_gear,
  output logic               o_step,
  output logic [PWM_W-1:0]   o_duty,
  output logic               o_pwm
);

  // state | meaning
  // PARK  | motor off, target duty 0
  // LOW   | quarter-scale target duty
  // MID   | half-scale target duty
  // HIGH  | full-scale target duty
  localparam logic [1:0] GEAR_PARK = 2'd0;
  localparam logic [1:0] GEAR_LOW  = 2'd1;
  localparam logic [1:0] GEAR_MID  = 2'd2;
  localparam logic [1:0] GEAR_HIGH = 2'd3;

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  localparam logic [PWM_W-1:0] DUTY_LOW  = {2'b01, {(PWM_W-2){1'b0}}};
  localparam logic [PWM_W-1:0] DUTY_MID  = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [PWM_W-1:0] DUTY_HIGH = {PWM_W{1'b1}};

  logic [CNT_LEN-1:0] cnt_prev_q, cnt_prev_d;
  logic [1:0]         gear_q, gear_d;
  logic               step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               pwm_q, pwm_d;
  logic               push_evt;
  logic               ramp_tick;
  logic [PWM_W-1:0]   duty_tgt;

  always_comb begin
    cnt_prev_d = i_push_cnt;
    // Any difference is one press, so a multi-count jump or a wrap still advances a single gear.
    push_evt   = (i_push_cnt != cnt_prev_q);

    gear_d = gear_q;
    step_d = 1'b0;
    if (i_estop) begin
      gear_d = GEAR_PARK;
    end else if (push_evt) begin
      gear_d = gear_q + 2'd1;
      step_d = 1'b1;
    end

    case (gear_q)
      GEAR_PARK: duty_tgt = '0;
      GEAR_LOW:  duty_tgt = DUTY_LOW;
      GEAR_MID:  duty_tgt = DUTY_MID;
      GEAR_HIGH: duty_tgt = DUTY_HIGH;
      default:   duty_tgt = '0;
    endcase

    ramp_tick = (div_q == DIV_LAST);
    div_d     = ramp_tick ? '0 : div_q + DIV_W'(1);

    duty_d = duty_q;
    if (i_estop) begin
      duty_d = '0;
    end else if (ramp_tick) begin
      if (duty_q < duty_tgt) begin
        duty_d = duty_q + PWM_W'(1);
      end else if (duty_q > duty_tgt) begin
        duty_d = duty_q - PWM_W'(1);
      end
    end

    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_d     = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_prev_q <= '0;
      gear_q     <= GEAR_PARK;
      step_q     <= 1'b0;
      div_q      <= '0;
      duty_q     <= '0;
      pwm_cnt_q  <= '0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_prev_q <= cnt_prev_d;
      gear_q     <= gear_d;
      step_q     <= step_d;
      div_q      <= div_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign o_gear = gear_q;
  assign o_step = step_q;
  assign o_duty = duty_q;
  assign o_pwm  = pwm_q;

endmodule

// File: tb/tb_push_gear_ctrl.sv
// Bench for push_gear_ctrl: directed scenarios plus random presses/estop/reset,
// all outputs compared each cycle against an integer reference model.
module tb_push_gear_ctrl;
  localparam int CNT_LEN  = 8;
  localparam int PWM_W    = 8;
  localparam int RAMP_DIV = 16;
  localparam int PWM_PER  = 1 << PWM_W;

  logic               i_clk = 1'b0;
  logic               i_rstn = 1'b0;
  logic [CNT_LEN-1:0] i_push_cnt = '0;
  logic               i_estop = 1'b0;
  logic [1:0]         o_gear;
  logic               o_step;
  logic [PWM_W-1:0]   o_duty;
  logic               o_pwm;

  push_gear_ctrl #(.CNT_LEN(CNT_LEN), .PWM_W(PWM_W), .RAMP_DIV(RAMP_DIV)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_push_cnt(i_push_cnt), .i_estop(i_estop),
    .o_gear(o_gear), .o_step(o_step), .o_duty(o_duty), .o_pwm(o_pwm)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integers, one update per rising edge.
  int m_prev = 0, m_gear = 0, m_step = 0, m_div = 0, m_duty = 0, m_pcnt = 0, m_pwm = 0;

  function automatic int gear_target(input int g);
    case (g)
      1:       return PWM_PER / 4;
      2:       return PWM_PER / 2;
      3:       return PWM_PER - 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      m_prev <= 0; m_gear <= 0; m_step <= 0; m_div <= 0;
      m_duty <= 0; m_pcnt <= 0; m_pwm <= 0;
    end else begin
      m_prev <= int'(i_push_cnt);
      if (i_estop) begin
        m_gear <= 0;
        m_step <= 0;
        m_duty <= 0;
      end else begin
        if (int'(i_push_cnt) != m_prev) begin
          m_gear <= (m_gear + 1) % 4;
          m_step <= 1;
        end else begin
          m_step <= 0;
        end
        if (m_div == RAMP_DIV - 1) begin
          if (m_duty < gear_target(m_gear))      m_duty <= m_duty + 1;
          else if (m_duty > gear_target(m_gear)) m_duty <= m_duty - 1;
        end
      end
      m_div  <= (m_div + 1) % RAMP_DIV;
      m_pcnt <= (m_pcnt + 1) % PWM_PER;
      m_pwm  <= (m_pcnt < m_duty) ? 1 : 0;
    end
  end

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk_eq("model_gear", int'(o_gear), m_gear);
      chk_eq("model_step", int'(o_step), m_step);
      chk_eq("model_duty", int'(o_duty), m_duty);
      chk_eq("model_pwm",  int'(o_pwm),  m_pwm);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_duty(input string tag, input int val, input int budget);
    int k = 0;
    while (int'(o_duty) != val && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    chk_eq(tag, int'(o_duty), val);
  endtask

  task automatic count_pwm(output int c);
    c = 0;
    repeat (PWM_PER) begin
      @(negedge i_clk);
      if (o_pwm) c++;
    end
  endtask

  initial begin
    int c;
    int s;
    i_rstn = 1'b0;
    cyc(3);
    chk_on = 1'b1;
    chk_eq("rst_gear", int'(o_gear), 0);
    chk_eq("rst_step", int'(o_step), 0);
    chk_eq("rst_duty", int'(o_duty), 0);
    chk_eq("rst_pwm",  int'(o_pwm),  0);
    i_rstn = 1'b1;
    cyc(5);

    // First press: pulse + LOW, ramp to quarter scale.
    i_push_cnt = 8'd1;
    @(negedge i_clk);
    chk_eq("first_step", int'(o_step), 1);
    chk_eq("first_gear", int'(o_gear), 1);
    @(negedge i_clk);
    chk_eq("first_step_end", int'(o_step), 0);
    cyc(64 * RAMP_DIV + RAMP_DIV);
    chk_eq("low_duty", int'(o_duty), 64);

    i_push_cnt = 8'd2;
    wait_duty("mid_duty", 128, 64 * RAMP_DIV + 40);
    count_pwm(c);
    chk_eq("pwm_half", c, 128);

    i_push_cnt = 8'd3;
    wait_duty("high_duty", 255, 127 * RAMP_DIV + 40);
    chk_eq("high_gear", int'(o_gear), 3);
    count_pwm(c);
    chk_eq("pwm_full", c, 255);

    // Emergency stop from full output.
    i_estop = 1'b1;
    @(negedge i_clk);
    chk_eq("estop_gear", int'(o_gear), 0);
    chk_eq("estop_duty", int'(o_duty), 0);
    i_push_cnt = 8'd4;
    @(negedge i_clk);
    chk_eq("estop_nostep", int'(o_step), 0);
    chk_eq("estop_hold_gear", int'(o_gear), 0);
    cyc(5);
    i_estop = 1'b0;
    @(negedge i_clk);
    chk_eq("estop_rel_step", int'(o_step), 0);
    chk_eq("estop_rel_gear", int'(o_gear), 0);
    count_pwm(c);
    chk_eq("pwm_zero", c, 0);

    // Wrap 255->0 and jump 3->7 each count once.
    i_push_cnt = 8'd255;
    @(negedge i_clk);
    chk_eq("ev255_gear", int'(o_gear), 1);
    cyc(9);
    i_push_cnt = 8'd0;
    @(negedge i_clk);
    chk_eq("wrap_step", int'(o_step), 1);
    chk_eq("wrap_gear", int'(o_gear), 2);
    @(negedge i_clk);
    chk_eq("wrap_once", int'(o_step), 0);
    cyc(8);
    i_push_cnt = 8'd3;
    cyc(10);
    chk_eq("pre_jump_gear", int'(o_gear), 3);
    i_push_cnt = 8'd7;
    @(negedge i_clk);
    chk_eq("jump_step", int'(o_step), 1);
    chk_eq("jump_gear", int'(o_gear), 0);
    @(negedge i_clk);
    chk_eq("jump_once", int'(o_step), 0);
    cyc(8);

    // Four spaced presses cycle through all gears.
    s = 0;
    for (int i = 0; i < 4; i++) begin
      i_push_cnt = i_push_cnt + 8'd1;
      @(negedge i_clk);
      if (o_step) s++;
      chk_eq("seq_gear", int'(o_gear), (i + 1) % 4);
      repeat (9) begin
        @(negedge i_clk);
        if (o_step) s++;
      end
    end
    chk_eq("seq_steps", s, 4);

    // Reset mid-ramp at duty 100, then release with a nonzero count.
    i_push_cnt = i_push_cnt + 8'd1;
    cyc(10);
    i_push_cnt = i_push_cnt + 8'd1;
    wait_duty("ramp_to_100", 100, 200 * RAMP_DIV);
    i_rstn = 1'b0;
    @(negedge i_clk);
    chk_eq("midrst_gear", int'(o_gear), 0);
    chk_eq("midrst_step", int'(o_step), 0);
    chk_eq("midrst_duty", int'(o_duty), 0);
    chk_eq("midrst_pwm",  int'(o_pwm),  0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk_eq("postrst_step", int'(o_step), 1);
    chk_eq("postrst_gear", int'(o_gear), 1);
    @(negedge i_clk);
    chk_eq("postrst_once", int'(o_step), 0);

    // Random presses, estop and occasional resets against the model.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 12)       i_push_cnt = i_push_cnt + 8'($urandom_range(1, 5));
      else if (r < 14)  i_estop = ~i_estop;
      i_rstn = (r == 199) ? 1'b0 : 1'b1;
      @(negedge i_clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/push_gear_ctrl.md
PUSH_GEAR_CTRL -- requirements
Module: push_gear_ctrl

Interface
REQ-001 SHALL have parameter CNT_LEN, default 8, width of the upstream press-count input.
REQ-002 SHALL have parameter PWM_W, default 8, width of the duty and PWM counters.
REQ-003 SHALL have parameter RAMP_DIV, default 16, number of clocks per duty ramp step (minimum 1).
REQ-004 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port i_push_cnt  input  CNT_LEN  debounced press count from the push-switch stage.
REQ-007 SHALL have port i_estop  input  1  emergency stop, active-high, level-sensitive.
REQ-008 SHALL have port o_gear  output  2  current gear: 0=PARK, 1=LOW, 2=MID, 3=HIGH.
REQ-009 SHALL have port o_step  output  1  one-cycle pulse per accepted gear advance.
REQ-010 SHALL have port o_duty  output  PWM_W  current ramped duty value.
REQ-011 SHALL have port o_pwm  output  1  motor PWM output.

Function
REQ-012 SHALL register i_push_cnt into cnt_prev every cycle, including while i_estop is high.
REQ-013 SHALL flag a press event in any cycle where i_push_cnt != cnt_prev, including wrap from all-ones to zero.
REQ-014 SHALL treat a change of more than 1 in a single cycle as exactly one event.
REQ-015 SHALL, on an event with i_estop low, advance o_gear PARK->LOW->MID->HIGH->PARK and pulse o_step high for one cycle; both update on the clock edge following the event cycle.
REQ-016 SHALL, while i_estop is high, force o_gear to PARK on the next edge, ignore events, and hold o_step low.
REQ-017 SHALL derive the target duty from o_gear: PARK=0, LOW=2^(PWM_W-2), MID=2^(PWM_W-1), HIGH=2^PWM_W-1.
REQ-018 SHALL run a ramp divider counting 0..RAMP_DIV-1 and wrapping to 0; the divider SHALL free-run regardless of gear.
REQ-019 SHALL, on each divider terminal count, move o_duty one LSB toward the target (+1 or -1), or hold it if equal; o_duty SHALL never overshoot.
REQ-020 SHALL, while i_estop is high, force o_duty to 0 on the next edge, bypassing the ramp.
REQ-021 SHALL, on a gear change mid-ramp, retarget immediately and continue stepping from the current o_duty without reset.
REQ-022 SHALL run a free-running PWM_W-bit counter that wraps from 2^PWM_W-1 to 0.
REQ-023 SHALL register o_pwm = (pwm_cnt < o_duty), giving one cycle of latency.
REQ-024 SHALL hold o_pwm constantly low at duty 0, and high for 2^PWM_W-1 of every 2^PWM_W cycles at maximum duty.

Reset
REQ-025 SHALL, while i_rstn is low at a clock edge, clear o_gear to PARK and clear o_step, o_duty, o_pwm, the divider, the PWM counter and cnt_prev to 0.
REQ-026 SHALL, on reset asserted mid-ramp or mid-PWM-period, abandon the ramp and PWM period with no residual pulse.
REQ-027 SHALL, on the first cycle after reset release with a nonzero i_push_cnt, register a single event per REQ-013 (cnt_prev resets to 0, matching the upstream reset value).

Verification
REQ-028 SHALL cover: with RAMP_DIV=16, i_push_cnt stepping 0->1 -> o_step one-cycle pulse, o_gear=1 one edge later, o_duty reaches 64 after 64x16 clocks.
REQ-029 SHALL cover: four increments spaced 10 cycles apart -> o_gear sequence 1,2,3,0 and four o_step pulses.
REQ-030 SHALL cover: i_push_cnt wrapping 255->0 -> exactly one event; a jump 3->7 in one cycle -> exactly one event.
REQ-031 SHALL cover: in HIGH with o_duty=255, i_estop asserted -> o_gear=0 and o_duty=0 next edge; an increment during estop -> no o_step and no gear change.
REQ-032 SHALL cover: o_duty=128 steady -> o_pwm high exactly 128 of every 256 cycles; o_duty=0 -> o_pwm never high.
REQ-033 SHALL cover: i_rstn low for one cycle mid-ramp at o_duty=100 -> all outputs 0 the next cycle, and o_gear=PARK.
